// File: rtl/disp_rdarb.sv
// Two-master AXI4 read arbiter: M0 fixed priority with a starvation guard for M1; one burst in flight.
// ARVALID rises the cycle after the grant decision; R channel is a combinational pass-through that stalls the slave via RREADY.
module disp_rdarb #(
  parameter int DW     = 64,
  parameter int STARVE = 4
) (
  input  logic          ACLK,
  input  logic          ARST,
  input  logic [31:0]   M0_ARADDR,
  input  logic [7:0]    M0_ARLEN,
  input  logic          M0_ARVALID,
  output logic          M0_ARREADY,
  output logic [DW-1:0] M0_RDATA,
  output logic          M0_RLAST,
  output logic          M0_RVALID,
  input  logic          M0_RREADY,
  input  logic [31:0]   M1_ARADDR,
  input  logic [7:0]    M1_ARLEN,
  input  logic          M1_ARVALID,
  output logic          M1_ARREADY,
  output logic [DW-1:0] M1_RDATA,
  output logic          M1_RLAST,
  output logic          M1_RVALID,
  input  logic          M1_RREADY,
  output logic [31:0]   ARADDR,
  output logic [7:0]    ARLEN,
  output logic          ARVALID,
  input  logic          ARREADY,
  input  logic [DW-1:0] RDATA,
  input  logic          RLAST,
  input  logic          RVALID,
  output logic          RREADY,
  output logic [1:0]    GNT
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [3:0] STARVE_L = 4'(STARVE);

  state_t      state_q;
  logic [1:0]  gnt_q;
  logic [3:0]  starve_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic        arvalid_q;
  logic        pick_m1_d;
  logic        in_data;
  logic        r_hs_last;

  // M1 wins when alone, or when M0 has been favoured STARVE times in a row over a waiting M1.
  assign pick_m1_d = M1_ARVALID && (!M0_ARVALID || (starve_q == STARVE_L));
  assign in_data   = (state_q == DATA);
  assign r_hs_last = RVALID && RREADY && RLAST;

  always_ff @(posedge ACLK or negedge ARST) begin
    if (!ARST) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      starve_q  <= 4'd0;
      araddr_q  <= 32'd0;
      arlen_q   <= 8'd0;
      arvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (M0_ARVALID || M1_ARVALID) begin
            state_q   <= ADDR;
            arvalid_q <= 1'b1;
            if (pick_m1_d) begin
              gnt_q    <= 2'b10;
              araddr_q <= M1_ARADDR;
              arlen_q  <= M1_ARLEN;
              starve_q <= 4'd0;
            end else begin
              gnt_q    <= 2'b01;
              araddr_q <= M0_ARADDR;
              arlen_q  <= M0_ARLEN;
              if (M1_ARVALID && (starve_q < STARVE_L)) starve_q <= starve_q + 4'd1;
            end
          end
        end
        ADDR: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (r_hs_last) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ARADDR  = araddr_q;
  assign ARLEN   = arlen_q;
  assign ARVALID = arvalid_q;
  assign GNT     = gnt_q;

  assign M0_ARREADY = ARREADY && arvalid_q && gnt_q[0];
  assign M1_ARREADY = ARREADY && arvalid_q && gnt_q[1];

  assign M0_RVALID = in_data && gnt_q[0] && RVALID;
  assign M0_RLAST  = in_data && gnt_q[0] && RLAST;
  assign M0_RDATA  = (in_data && gnt_q[0]) ? RDATA : '0;
  assign M1_RVALID = in_data && gnt_q[1] && RVALID;
  assign M1_RLAST  = in_data && gnt_q[1] && RLAST;
  assign M1_RDATA  = (in_data && gnt_q[1]) ? RDATA : '0;

  assign RREADY = in_data && ((gnt_q[0] && M0_RREADY) || (gnt_q[1] && M1_RREADY));

endmodule

// File: doc/disp_rdarb.md
Name: disp_rdarb

Overview:
- Two-requester AXI4 read-channel arbiter in front of the single DDR read port of the display IP.
- Requester 0 (M0) is the VRAM display reader; requester 1 (M1) is a secondary reader (e.g. cursor/overlay fetch).
- Handles one burst at a time: it grants one master, forwards its AR beat, routes R beats back until RLAST, then re-arbitrates.
- M0 has fixed priority, bounded by a starvation guard so M1 is never locked out during active display.

Parameters:
- DW, 64, RDATA width in bits.
- STARVE, 4, number of consecutive M0 grants while M1 is waiting that forces one M1 grant (legal range 1..15).

Ports:
- ACLK  in  1  system clock
- ARST  in  1  reset, asynchronous assert, active-low
- M0_ARADDR  in  32  M0 read address
- M0_ARLEN  in  8  M0 burst length-1
- M0_ARVALID  in  1  M0 address valid
- M0_ARREADY  out  1  M0 address accepted
- M0_RDATA  out  DW  read data to M0
- M0_RLAST  out  1  last beat to M0
- M0_RVALID  out  1  data valid to M0
- M0_RREADY  in  1  M0 data ready
- M1_ARADDR, M1_ARLEN, M1_ARVALID, M1_ARREADY, M1_RDATA, M1_RLAST, M1_RVALID, M1_RREADY: same as the M0 ports, for M1
- ARADDR  out  32  to slave
- ARLEN  out  8  to slave
- ARVALID  out  1  to slave
- ARREADY  in  1  from slave
- RDATA  in  DW  from slave
- RLAST  in  1  from slave
- RVALID  in  1  from slave
- RREADY  out  1  to slave
- GNT  out  2  current owner, one-hot, 00 when idle (debug/status)

Behaviour:
- Reset (ARST=0, async): state IDLE, GNT=00, starve counter=0, ARVALID=0, ARADDR=0, ARLEN=0, all Mx_ARREADY=0, Mx_RVALID=0, RREADY=0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - M0 only requesting: grant M0.
  - M1 only requesting: grant M1.
  - Both requesting: grant M1 if starve counter == STARVE, else grant M0.
  - On grant, latch the winner's ARADDR/ARLEN into registered slave outputs, set ARVALID=1, set GNT, go to ADDR. Grant decision is made the cycle a request is seen in IDLE; ARVALID rises the next cycle.
- ADDR:
  - ARVALID held with stable ARADDR/ARLEN until ARREADY=1.
  - In the ARREADY cycle: the granted Mx_ARREADY is pulsed high (combinational from ARREADY & ARVALID & grant), ARVALID drops next edge, go to DATA.
  - The non-granted master's ARREADY is 0 throughout; its ARVALID stays pending, per AXI.
- DATA:
  - Combinational pass-through: granted Mx_RDATA/Mx_RLAST/Mx_RVALID = slave RDATA/RLAST/RVALID; RREADY = granted Mx_RREADY.
  - Non-granted Mx_RVALID=0.
  - On the beat where RVALID & RREADY & RLAST: go to IDLE, GNT=00.
  - Re-arbitration occurs in IDLE on the following cycle (minimum 1 idle cycle between bursts).
- Starve counter (4-bit, saturating at STARVE):
  - Increments when M0 is granted while M1_ARVALID=1.
  - Clears to 0 when M1 is granted.
  - Unchanged when M0 is granted with M1 idle.
- Masters hold ARVALID until ARREADY (AXI rule). Arbiter behaviour on a master dropping ARVALID early is undefined; the testbench flags it as an error.
- R beats arriving while not in DATA are not expected. RREADY=0 outside DATA, so the slave stalls.
- Reset mid-burst: all state clears immediately. The slave side is reset by the same ARST.

Test Plan:
- Single M0 burst: M0_ARADDR=0x1000_0000, ARLEN=15, ARREADY after 3 cycles, 16 R beats -> slave ARADDR=0x1000_0000, ARLEN=15, M0_ARREADY one pulse, 16 M0_RVALID beats with RLAST on beat 16, GNT 01->00.
- Simultaneous requests, counter 0: both ARVALID in the same cycle -> M0 granted first, M1 granted after M0's RLAST plus 1 idle cycle.
- Starvation, STARVE=4: M0 requests back-to-back and M1 held pending -> M0 wins 4 bursts, the 5th grant goes to M1, counter returns to 0.
- Backpressure: M1 burst with M1_RREADY toggled 1,0,0,1 -> RREADY mirrors M1_RREADY, no beat lost or duplicated, RDATA sequence 0..7 intact.
- Async reset during DATA beat 5 of 16 -> all outputs 0 within the reset cycle, GNT=00; a new M0 request after release is granted normally.
- Isolation: during an M0 burst -> M1_RVALID stays 0 and M1_ARREADY stays 0 while M1_ARVALID=1.
